// File: rtl/quickq_ctrl.sv
// rtl/quickq_ctrl.sv - sorted priority queue controller over a single-port BRAM
// Optional feature macro: QUICKQ_DROP_CNT_EN (rejected-request counter)
module quickq_ctrl #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq,
  input  logic                     deq,
  input  logic [W-1:0]             din,
  output logic                     ready,
  output logic [W-1:0]             dout,
  output logic                     dout_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH)-1:0] ram_addr,
  output logic                     ram_we,
  output logic [W-1:0]             ram_wdata,
  input  logic [W-1:0]             ram_rdata,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ENQ_RD    = 3'd1;
  localparam logic [2:0] S_ENQ_CMP   = 3'd2;
  localparam logic [2:0] S_ENQ_TAIL  = 3'd3;
  localparam logic [2:0] S_DEQ_RD    = 3'd4;
  localparam logic [2:0] S_DEQ_SHIFT = 3'd5;
  localparam logic [2:0] S_DEQ_END   = 3'd6;

  logic [2:0]    state;
  logic [CW-1:0] idx;
  logic [CW-1:0] idx_inc;
  logic [W-1:0]  hold;
  logic          one_left;
  logic          accept_deq;
  logic          accept_enq;

  assign ready      = (state == S_IDLE);
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign one_left   = (count == CW'(1));
  assign idx_inc    = idx + CW'(1);
  // deq wins over a simultaneous enq; the enq is then dropped
  assign accept_deq = ready && deq && !empty;
  assign accept_enq = ready && enq && !deq && !full;

  // Main FSM: insertion walks the array swapping the carried key downward,
  // removal shifts every entry up by one slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      count      <= '0;
      idx        <= '0;
      hold       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept_deq) begin
            idx   <= '0;
            state <= S_DEQ_RD;
          end else if (accept_enq) begin
            hold  <= din;
            idx   <= '0;
            state <= empty ? S_ENQ_TAIL : S_ENQ_RD;
          end
        end
        S_ENQ_RD: state <= S_ENQ_CMP;
        S_ENQ_CMP: begin
          // strict compare keeps equal keys in insertion order
          if (hold > ram_rdata) hold <= ram_rdata;
          idx   <= idx_inc;
          state <= (idx_inc == count) ? S_ENQ_TAIL : S_ENQ_RD;
        end
        S_ENQ_TAIL: begin
          count <= count + CW'(1);
          state <= S_IDLE;
        end
        S_DEQ_RD: begin
          // the head was read while IDLE presented address 0
          if (idx == '0) begin
            dout       <= ram_rdata;
            dout_valid <= 1'b1;
          end
          state <= one_left ? S_DEQ_END : S_DEQ_SHIFT;
        end
        S_DEQ_SHIFT: begin
          idx   <= idx_inc;
          state <= (idx_inc < count - CW'(1)) ? S_DEQ_RD : S_DEQ_END;
        end
        S_DEQ_END: begin
          count <= count - CW'(1);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // BRAM port drive; IDLE keeps reading address 0 so the head is ready at once
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = hold;
    case (state)
      S_ENQ_RD: ram_addr = idx[AW-1:0];
      S_ENQ_CMP: begin
        ram_addr = idx[AW-1:0];
        ram_we   = (hold > ram_rdata);
      end
      S_ENQ_TAIL: begin
        ram_addr = idx[AW-1:0];
        ram_we   = 1'b1;
      end
      S_DEQ_RD: ram_addr = one_left ? idx[AW-1:0] : idx_inc[AW-1:0];
      S_DEQ_SHIFT: begin
        ram_addr  = idx[AW-1:0];
        ram_we    = 1'b1;
        ram_wdata = ram_rdata;
      end
      default: ;
    endcase
  end

`ifdef QUICKQ_DROP_CNT_EN
  logic reject;
  assign reject = ready && ((deq && empty) || (enq && deq && !empty) || (enq && !deq && full));

  // Saturating count of rejected requests
  always_ff @(posedge clk) begin
    if (rst) drop_cnt <= '0;
    else if (reject && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: doc/quickq_ctrl.md
QUICKQ_CTRL -- requirements
Module: quickq_ctrl

Interface
REQ-001 Parameter DEPTH, default 16: number of queue entries (power of two, at least 2).
REQ-002 Parameter W, default 32: key width in bits.
REQ-003 clk  in  1  system clock; single clock domain, all state updates on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 enq  in  1  enqueue request; sampled only when ready=1.
REQ-006 deq  in  1  dequeue request; sampled only when ready=1.
REQ-007 din  in  W  key to enqueue.
REQ-008 ready  out  1  high in IDLE only; requests are accepted on the cycle with ready=1.
REQ-009 dout  out  W  dequeued key; valid while dout_valid=1.
REQ-010 dout_valid  out  1  one-cycle pulse when dout carries the dequeued head.
REQ-011 full / empty  out  1 each  count==DEPTH / count==0.
REQ-012 count  out  $clog2(DEPTH)+1  number of stored entries.
REQ-013 ram_addr  out  $clog2(DEPTH)  address to the single-port BRAM.
REQ-014 ram_we  out  1  BRAM write enable.
REQ-015 ram_wdata  out  W  BRAM write data.
REQ-016 ram_rdata  in  W  BRAM read data; valid one cycle after ram_addr is presented with ram_we=0.
REQ-017 drop_cnt  out  16  count of rejected requests; see Configuration.

Function
REQ-018 The queue SHALL be kept as a sorted array in the BRAM: index 0 holds the largest key, entries are non-increasing up to index count-1, and equal keys keep insertion order.
REQ-019 FSM states: IDLE, ENQ_RD, ENQ_CMP, ENQ_TAIL, DEQ_RD, DEQ_SHIFT, DEQ_END.
REQ-020 IDLE: when deq=1 and empty=0, the FSM SHALL go to DEQ_RD with idx=0; deq takes priority over a simultaneous enq, and that enq is dropped.
REQ-021 IDLE: when enq=1, deq=0 and full=0, the FSM SHALL load hold<=din and idx<=0, then go to ENQ_TAIL if empty=1, otherwise to ENQ_RD.
REQ-022 ENQ_RD: present ram_addr=idx with ram_we=0, then go to ENQ_CMP.
REQ-023 ENQ_CMP: if hold > ram_rdata (unsigned), write hold at idx and load hold<=ram_rdata; otherwise no write. Then idx++; go to ENQ_TAIL if the new idx==count, else to ENQ_RD.
REQ-024 ENQ_TAIL: write hold at idx, count++, return to IDLE.
REQ-025 Enqueue latency from acceptance to ready=1 SHALL be 2*count_before+2 cycles.
REQ-026 DEQ_RD: present ram_addr=idx+1 with a read (skipped when count==1); on the first visit, ram_rdata of address 0 is already captured.
REQ-027 The head read is issued in the acceptance cycle (ram_addr=0): dout<=ram_rdata with dout_valid=1 in the cycle after acceptance.
REQ-028 DEQ_SHIFT: write ram_rdata (entry idx+1) to idx, then idx++; go to DEQ_RD while idx+1 < count-1, else to DEQ_END.
REQ-029 DEQ_END: count--, return to IDLE.
REQ-030 Rejected requests (enq while full and deq=0; deq while empty; enq dropped under REQ-020) SHALL leave the state unchanged.
REQ-031 enq and deq seen while ready=0 SHALL be ignored and not counted.
REQ-032 full, empty and count SHALL change only in ENQ_TAIL and DEQ_END.

Reset
REQ-033 rst=1 SHALL force IDLE, count=0, idx=0, hold=0, dout=0, dout_valid=0, ram_we=0, ram_addr=0, drop_cnt=0, empty=1, full=0, ready=1 on the next edge, including in the middle of an operation.
REQ-034 Reset SHALL NOT clear BRAM contents; logically the queue is empty after reset.

Configuration
REQ-035 With QUICKQ_DROP_CNT_EN defined, drop_cnt SHALL increment (saturating at 16'hFFFF) once per request rejected under REQ-030.
REQ-036 With QUICKQ_DROP_CNT_EN undefined, drop_cnt SHALL be constant 0 and the counter logic SHALL be absent.

Verification
REQ-037 Reset, then enq 5, 9, 2, 9 -> BRAM[0..3] = 9, 9, 5, 2 (first 9 ahead of second 9), count=4.
REQ-038 Empty queue, deq pulse -> no dout_valid; drop_cnt=1 with the macro defined, 0 without it.
REQ-039 Fill with 1..16 (DEPTH=16), then enq 99 -> full=1, rejected, head unchanged at 16.
REQ-040 Queue holds {7, 3}, enq 4 and deq asserted together -> dout=7 with dout_valid, count=1, 4 not stored.
REQ-041 rst asserted during an enqueue into a queue of 10 -> next cycle ready=1, count=0, empty=1; a following enq 8 then deq returns 8.
REQ-042 Enq 3 into a queue of 3 entries -> ready returns high exactly 8 cycles after acceptance.
